// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : ID-stage issue control. Decodes the ID instruction, tracks
//               in-flight destinations in EX/MEM/WB, stalls on RAW hazards
//               and for a fixed number of bubbles after a branch or jump.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter bit          WB_BYPASS  = 1'b1,
  parameter int unsigned BR_BUBBLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic        flush,
  output logic        stall,
  output logic        issue,
  output logic        hz_raw,
  output logic        hz_ctrl,
  output logic        ex_valid,
  output logic [4:0]  ex_dest
);

  localparam logic [1:0] c_br_bubbles = 2'(BR_BUBBLES);
  localparam logic       c_wb_check   = ~WB_BYPASS;

  logic [5:0] w_op;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic       w_use_rs;
  logic       w_use_rt;
  logic       w_has_dest;
  logic       w_branch;
  logic [4:0] w_dest;
  logic       w_rs_hit;
  logic       w_rt_hit;
  logic       w_unused_bits;

  logic       r_ex_valid;
  logic [4:0] r_ex_dest;
  logic       r_mem_valid;
  logic [4:0] r_mem_dest;
  logic       r_wb_valid;
  logic [4:0] r_wb_dest;
  logic [1:0] r_bcnt;

  assign w_op          = id_instr[31:26];
  assign w_rs          = id_instr[25:21];
  assign w_rt          = id_instr[20:16];
  assign w_rd          = id_instr[15:11];
  assign w_unused_bits = ^id_instr[10:0];

  always_comb begin
    w_use_rs   = 1'b0;
    w_use_rt   = 1'b0;
    w_has_dest = 1'b0;
    w_branch   = 1'b0;
    w_dest     = 5'd0;
    case (w_op)
      6'b000000: begin
        w_use_rs   = 1'b1;
        w_use_rt   = 1'b1;
        w_has_dest = 1'b1;
        w_dest     = w_rd;
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001010,
      6'b100011, 6'b100000: begin
        w_use_rs   = 1'b1;
        w_has_dest = 1'b1;
        w_dest     = w_rt;
      end
      6'b101011, 6'b101000: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      6'b000100, 6'b000101: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
        w_branch = 1'b1;
      end
      6'b000001: begin
        w_use_rs = 1'b1;
        w_branch = 1'b1;
      end
      6'b000010: w_branch = 1'b1;
      default: ;
    endcase
  end

  // $0 is hardwired, so it can never carry a dependency.
  assign w_rs_hit = w_use_rs && (w_rs != 5'd0) &&
                    ((r_ex_valid  && (r_ex_dest  == w_rs)) ||
                     (r_mem_valid && (r_mem_dest == w_rs)) ||
                     (c_wb_check && r_wb_valid && (r_wb_dest == w_rs)));
  assign w_rt_hit = w_use_rt && (w_rt != 5'd0) &&
                    ((r_ex_valid  && (r_ex_dest  == w_rt)) ||
                     (r_mem_valid && (r_mem_dest == w_rt)) ||
                     (c_wb_check && r_wb_valid && (r_wb_dest == w_rt)));

  assign hz_raw   = id_valid & ~flush & (w_rs_hit | w_rt_hit);
  assign hz_ctrl  = (r_bcnt != 2'd0);
  assign stall    = hz_raw | hz_ctrl;
  assign issue    = id_valid & ~flush & ~stall;
  assign ex_valid = r_ex_valid;
  assign ex_dest  = r_ex_dest;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_dest   <= 5'd0;
      r_mem_valid <= 1'b0;
      r_mem_dest  <= 5'd0;
      r_wb_valid  <= 1'b0;
      r_wb_dest   <= 5'd0;
      r_bcnt      <= 2'd0;
    end else begin
      r_wb_valid  <= r_mem_valid;
      r_wb_dest   <= r_mem_dest;
      r_mem_valid <= r_ex_valid;
      r_mem_dest  <= r_ex_dest;
      r_ex_valid  <= issue & w_has_dest & (w_dest != 5'd0);
      r_ex_dest   <= w_dest;
      if (flush) begin
        r_bcnt <= 2'd0;
      end else if (issue && w_branch) begin
        r_bcnt <= c_br_bubbles;
      end else if (r_bcnt != 2'd0) begin
        r_bcnt <= r_bcnt - 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Four differently parameterised scoreboards driven in lockstep
//               and compared against a cycle-stamped register-writer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  localparam int  NDUT = 4;
  localparam bit  WBP [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam int  BRB [NDUT] = '{2, 2, 0, 3};
  localparam logic [5:0] OPS [14] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h20,
                                      6'h2B, 6'h28, 6'h04, 6'h05, 6'h01, 6'h02, 6'h3F};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = 32'd0;
  logic        flush = 1'b0;

  logic [NDUT-1:0] stall_o, issue_o, raw_o, ctrl_o, exv_o;
  logic [4:0]      exd_o [NDUT];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    hazard_scoreboard #(.WB_BYPASS(WBP[g]), .BR_BUBBLES(BRB[g])) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .id_valid (id_valid),
      .id_instr (id_instr),
      .flush    (flush),
      .stall    (stall_o[g]),
      .issue    (issue_o[g]),
      .hz_raw   (raw_o[g]),
      .hz_ctrl  (ctrl_o[g]),
      .ex_valid (exv_o[g]),
      .ex_dest  (exd_o[g])
    );
  end

  typedef struct {
    bit         use_rs, use_rt, has_dest, br;
    logic [4:0] rs, rt, dest;
  } dec_t;

  typedef struct packed {
    logic raw, ctrl, stall, issue;
  } exp_t;

  // Model: cycle at which the latest writer of each register issued, and the
  // cycle of the latest branch issue. Hazards are judged by age in cycles.
  int         cyc;
  int         wcyc   [NDUT][32];
  int         lastbr [NDUT];
  bit         exv_m  [NDUT];
  logic [4:0] exd_m  [NDUT];
  bit         exd_known [NDUT];

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    logic [5:0] op;
    op = ins[31:26];
    d.rs = ins[25:21];
    d.rt = ins[20:16];
    d.use_rs = 0; d.use_rt = 0; d.has_dest = 0; d.br = 0; d.dest = 5'd0;
    if (op == 6'h00) begin
      d.use_rs = 1; d.use_rt = 1; d.has_dest = 1; d.dest = ins[15:11];
    end else if (op inside {6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h20}) begin
      d.use_rs = 1; d.has_dest = 1; d.dest = ins[20:16];
    end else if (op inside {6'h2B, 6'h28}) begin
      d.use_rs = 1; d.use_rt = 1;
    end else if (op inside {6'h04, 6'h05}) begin
      d.use_rs = 1; d.use_rt = 1; d.br = 1;
    end else if (op == 6'h01) begin
      d.use_rs = 1; d.br = 1;
    end else if (op == 6'h02) begin
      d.br = 1;
    end
    return d;
  endfunction

  function automatic bit busy(input int k, input logic [4:0] r);
    int win;
    win = WBP[k] ? 2 : 3;
    return (r != 5'd0) && ((cyc - wcyc[k][r]) <= win);
  endfunction

  function automatic exp_t expect_comb(input int k);
    exp_t e;
    dec_t d;
    d = decode(id_instr);
    e.raw   = id_valid && !flush &&
              ((d.use_rs && busy(k, d.rs)) || (d.use_rt && busy(k, d.rt)));
    e.ctrl  = (cyc - lastbr[k]) <= BRB[k];
    e.stall = e.raw | e.ctrl;
    e.issue = id_valid && !flush && !e.stall;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      for (int k = 0; k < NDUT; k++) begin
        lastbr[k] = -1000;
        exv_m[k] = 0;
        exd_m[k] = 5'd0;
        exd_known[k] = 1;
        for (int r = 0; r < 32; r++) wcyc[k][r] = -1000;
      end
    end else begin
      dec_t d;
      exp_t e;
      d = decode(id_instr);
      for (int k = 0; k < NDUT; k++) begin
        e = expect_comb(k);
        if (e.issue && d.has_dest && d.dest != 5'd0) begin
          wcyc[k][d.dest] = cyc;
          exv_m[k] = 1;
          exd_m[k] = d.dest;
          exd_known[k] = 1;
        end else begin
          exv_m[k] = 0;
          exd_known[k] = 0;
        end
        if (flush) lastbr[k] = -1000;
        else if (e.issue && d.br) lastbr[k] = cyc;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NDUT; k++) begin
      e = expect_comb(k);
      chk($sformatf("hz_raw[%0d]", k),   int'(raw_o[k]),   int'(e.raw));
      chk($sformatf("hz_ctrl[%0d]", k),  int'(ctrl_o[k]),  int'(e.ctrl));
      chk($sformatf("stall[%0d]", k),    int'(stall_o[k]), int'(e.stall));
      chk($sformatf("issue[%0d]", k),    int'(issue_o[k]), int'(e.issue));
      chk($sformatf("ex_valid[%0d]", k), int'(exv_o[k]),   int'(exv_m[k]));
      if (exd_known[k])
        chk($sformatf("ex_dest[%0d]", k), int'(exd_o[k]), int'(exd_m[k]));
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl);
    @(posedge clk);
    #1;
    id_valid = v;
    id_instr = ins;
    flush    = fl;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    id_valid = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] ins;
    #1 rst_n = 1'b0;
    #20 rst_n = 1'b1;

    // Back-to-back RAW: bypassed (dut 0) vs checked WB (dut 1).
    do_reset();
    drive(1, 32'h20010005, 0);
    chk("A0 issue0", int'(issue_o[0]), 1);
    chk("A0 stall0", int'(stall_o[0]), 0);
    drive(1, 32'h00221820, 0);
    chk("A1 stall0", int'(stall_o[0]), 1);
    chk("A1 raw0", int'(raw_o[0]), 1);
    chk("A1 exdest0", int'(exd_o[0]), 1);
    chk("A1 stall1", int'(stall_o[1]), 1);
    drive(1, 32'h00221820, 0);
    chk("A2 stall0", int'(stall_o[0]), 1);
    chk("A2 stall1", int'(stall_o[1]), 1);
    drive(1, 32'h00221820, 0);
    chk("A3 issue0", int'(issue_o[0]), 1);
    chk("A3 raw1", int'(raw_o[1]), 1);
    drive(1, 32'h00221820, 0);
    chk("A4 exvalid0", int'(exv_o[0]), 1);
    chk("A4 exdest0", int'(exd_o[0]), 3);
    chk("A4 issue1", int'(issue_o[1]), 1);
    #1;
    rst_n = 1'b0;
    id_valid = 1'b0;
    #1;
    chk("RST exvalid0", int'(exv_o[0]), 0);
    chk("RST exdest0", int'(exd_o[0]), 0);
    chk("RST stall0", int'(stall_o[0]), 0);
    chk("RST ctrl0", int'(ctrl_o[0]), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Load chain on dut 0.
    do_reset();
    drive(1, 32'h00221820, 0);
    chk("B0 issue0", int'(issue_o[0]), 1);
    drive(1, 32'h8C640000, 0);
    chk("B1 stall0", int'(stall_o[0]), 1);
    drive(1, 32'h8C640000, 0);
    chk("B2 stall0", int'(stall_o[0]), 1);
    drive(1, 32'h8C640000, 0);
    chk("B3 issue0", int'(issue_o[0]), 1);
    drive(1, 32'h00812822, 0);
    chk("B4 raw0", int'(raw_o[0]), 1);
    drive(1, 32'h00812822, 0);
    chk("B5 stall0", int'(stall_o[0]), 1);
    drive(1, 32'h00812822, 0);
    chk("B6 issue0", int'(issue_o[0]), 1);
    drive(1, 32'hAC400004, 0);
    chk("B7 issue0", int'(issue_o[0]), 1);
    chk("B7 stall0", int'(stall_o[0]), 0);
    drive(0, 32'h0, 0);
    chk("B8 exvalid0", int'(exv_o[0]), 0);

    // Branch and jump bubbles; dut 2 has no bubbles.
    do_reset();
    drive(1, 32'h10220003, 0);
    chk("C0 issue0", int'(issue_o[0]), 1);
    drive(1, 32'h10220003, 0);
    chk("C1 ctrl0", int'(ctrl_o[0]), 1);
    chk("C1 exvalid0", int'(exv_o[0]), 0);
    chk("C1 issue0", int'(issue_o[0]), 0);
    chk("C1 ctrl2", int'(ctrl_o[2]), 0);
    chk("C1 issue2", int'(issue_o[2]), 1);
    drive(1, 32'h10220003, 0);
    chk("C2 ctrl0", int'(ctrl_o[0]), 1);
    chk("C2 exvalid0", int'(exv_o[0]), 0);
    drive(1, 32'h08000010, 0);
    chk("C3 ctrl0", int'(ctrl_o[0]), 0);
    chk("C3 issue0", int'(issue_o[0]), 1);
    drive(1, 32'h08000010, 0);
    chk("C4 ctrl0", int'(ctrl_o[0]), 1);
    chk("C4 raw0", int'(raw_o[0]), 0);
    drive(1, 32'h08000010, 0);
    chk("C5 ctrl0", int'(ctrl_o[0]), 1);
    drive(0, 32'h0, 0);
    chk("C6 ctrl0", int'(ctrl_o[0]), 0);

    // Simultaneous RAW + branch bubble, then flush (dut 1).
    do_reset();
    drive(1, 32'h20010005, 0);
    chk("D0 issue1", int'(issue_o[1]), 1);
    drive(1, 32'h10000000, 0);
    chk("D1 issue1", int'(issue_o[1]), 1);
    drive(1, 32'h00221820, 0);
    chk("D2 raw1", int'(raw_o[1]), 1);
    chk("D2 ctrl1", int'(ctrl_o[1]), 1);
    #1 flush = 1'b1;
    #1;
    chk("D2f issue1", int'(issue_o[1]), 0);
    chk("D2f raw1", int'(raw_o[1]), 0);
    chk("D2f ctrl1", int'(ctrl_o[1]), 1);
    drive(1, 32'hFC000000, 0);
    chk("D3 ctrl1", int'(ctrl_o[1]), 0);
    chk("D3 issue1", int'(issue_o[1]), 1);
    drive(0, 32'h0, 0);
    chk("D4 exvalid1", int'(exv_o[1]), 0);

    // Randomised traffic with small register numbers to provoke hazards.
    ins = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 9) < 7) begin
          ins = $urandom;
          ins[31:26] = OPS[$urandom_range(0, 13)];
          ins[25:21] = 5'($urandom_range(0, 7));
          ins[20:16] = 5'($urandom_range(0, 7));
          ins[15:11] = 5'($urandom_range(0, 7));
        end
        drive(1'($urandom_range(0, 9) < 8), ins, 1'($urandom_range(0, 19) == 0));
      end
    end
    drive(0, 32'h0, 0);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
